// File: rtl/care_menu.sv
// care_menu -- player-side care controller.
//
// Conditions the three front-panel buttons (2-flop sync, debounce, press
// pulse), runs a cursor over the six care actions and fires a one-cycle
// one-hot pulse on the action bus, refusing actions against a stat already
// at 0. A cooldown holds the block busy between consecutive actions.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   btn_next/select/back      raw asynchronous active-high buttons
//   hunger..social            current stat levels, menu indices 0..5
//   action                    one-hot single-cycle action pulse (bits 7:6 = 0)
//   cursor                    current menu index 0..5
//   busy                      high while firing or cooling down
//   reject                    single-cycle pulse when a select is refused
module care_menu #(
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned COOLDOWN_CYCLES = 27_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_next,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  output logic [7:0] action,
  output logic [2:0] cursor,
  output logic       busy,
  output logic       reject
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    BROWSE,
    FIRE,
    COOLDOWN
  } state_t;

  // Button index: 0 = next, 1 = select, 2 = back.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    level_q;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {btn_back, btn_select, btn_next};

  // The counter runs only while the synchronized level disagrees with the
  // accepted level; the accepted level flips on the last count of a run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      press   <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  state_t        state, state_n;
  logic [2:0]    cursor_n;
  logic          reject_n;
  logic [CW-1:0] cd_cnt, cd_cnt_n;
  logic [3:0]    stat_sel;

  always_comb begin
    case (cursor)
      3'd0:    stat_sel = hunger;
      3'd1:    stat_sel = happiness;
      3'd2:    stat_sel = health;
      3'd3:    stat_sel = hygiene;
      3'd4:    stat_sel = energy;
      3'd5:    stat_sel = social;
      default: stat_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BROWSE;
      cursor <= '0;
      reject <= 1'b0;
      cd_cnt <= '0;
    end else begin
      state  <= state_n;
      cursor <= cursor_n;
      reject <= reject_n;
      cd_cnt <= cd_cnt_n;
    end
  end

  // Events are only consumed in BROWSE; in FIRE/COOLDOWN they are dropped.
  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    reject_n = 1'b0;
    cd_cnt_n = cd_cnt;
    case (state)
      BROWSE: begin
        cd_cnt_n = '0;
        if (press[2]) begin
          cursor_n = '0;
        end else if (press[1]) begin
          if (stat_sel == 4'd0) reject_n = 1'b1;
          else                  state_n  = FIRE;
        end else if (press[0]) begin
          cursor_n = (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
        end
      end
      FIRE: begin
        state_n  = COOLDOWN;
        cd_cnt_n = '0;
      end
      COOLDOWN: begin
        if (cd_cnt == CD_LAST) begin
          state_n  = BROWSE;
          cd_cnt_n = '0;
        end else begin
          cd_cnt_n = cd_cnt + CW'(1);
        end
      end
      default: begin
        state_n  = BROWSE;
        cd_cnt_n = '0;
      end
    endcase
  end

  always_comb begin
    action = '0;
    if (state == FIRE) action[cursor] = 1'b1;
  end

  assign busy = (state != BROWSE);

endmodule

// File: tb/tb_care_menu.sv
module tb_care_menu;

  localparam int unsigned DB = 4;
  localparam int unsigned CD = 8;
  localparam int unsigned HL = DB + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_select = 1'b0;
  logic       btn_back = 1'b0;
  logic [3:0] st [6];
  logic [7:0] action;
  logic [2:0] cursor;
  logic       busy;
  logic       reject;

  int n_cmp = 0;
  int n_bad = 0;

  care_menu #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_next  (btn_next),
    .btn_select(btn_select),
    .btn_back  (btn_back),
    .hunger    (st[0]),
    .happiness (st[1]),
    .health    (st[2]),
    .hygiene   (st[3]),
    .energy    (st[4]),
    .social    (st[5]),
    .action    (action),
    .cursor    (cursor),
    .busy      (busy),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Debounce is expressed as a window over raw samples:
  // the accepted level becomes v once the D synchronized samples all equal v.
  bit hist [3][HL];
  bit l1 [3];
  bit l2 [3];
  bit mp [3];
  int m_state;     // 0 browse, 1 fire, 2 cooldown
  int m_cur;
  int m_left;
  bit m_rej;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < HL; j++) hist[b][j] = 1'b0;
      l1[b] = 1'b0;
      l2[b] = 1'b0;
      mp[b] = 1'b0;
    end
    m_state = 0;
    m_cur = 0;
    m_left = 0;
    m_rej = 1'b0;
  endtask

  task automatic model_step();
    bit rawv [3];
    bit np [3];
    bit v;
    bit same;
    rawv[0] = btn_next;
    rawv[1] = btn_select;
    rawv[2] = btn_back;
    m_rej = 1'b0;
    case (m_state)
      0: begin
        if (mp[2]) m_cur = 0;
        else if (mp[1]) begin
          if (st[m_cur] == 4'd0) m_rej = 1'b1;
          else m_state = 1;
        end else if (mp[0]) m_cur = (m_cur + 1) % 6;
      end
      1: begin
        m_state = 2;
        m_left = CD;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
    endcase
    for (int b = 0; b < 3; b++) begin
      np[b] = l1[b] & ~l2[b];
      for (int j = HL - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = rawv[b];
      v = hist[b][2];
      same = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[b][j] != v) same = 1'b0;
      l2[b] = l1[b];
      if (same) l1[b] = v;
      mp[b] = np[b];
    end
  endtask

  task automatic compare_all();
    logic [7:0] ea;
    ea = (m_state == 1) ? (8'd1 << m_cur) : 8'd0;
    check("action", {24'd0, action}, {24'd0, ea});
    check("cursor", {29'd0, cursor}, m_cur);
    check("busy", {31'd0, busy}, {31'd0, m_state != 0});
    check("reject", {31'd0, reject}, {31'd0, m_rej});
  endtask

  task automatic run(input int n, input bit nx, input bit se, input bit bk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_next = nx;
      btn_select = se;
      btn_back = bk;
      @(posedge clk);
      model_step();
      #1 compare_all();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_next = 1'b0;
    btn_select = 1'b0;
    btn_back = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 compare_all();
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_stats(input int v);
    for (int i = 0; i < 6; i++) st[i] = 4'(v);
  endtask

  initial begin
    int hold [3];
    bit val [3];
    set_stats(5);
    model_reset();
    do_reset();
    run(3, 0, 0, 0);

    // bouncing next, then a steady press: one increment
    for (int i = 0; i < 5; i++) begin
      run(2, 1, 0, 0);
      run(2, 0, 0, 0);
    end
    run(15, 1, 0, 0);
    run(10, 0, 0, 0);

    // clean presses: wrap around, then back
    for (int i = 0; i < 8; i++) begin
      run(8, 1, 0, 0);
      run(8, 0, 0, 0);
    end
    run(8, 0, 0, 1);
    run(8, 0, 0, 0);

    // fire on health, then a select during cooldown
    run(8, 1, 0, 0);
    run(8, 0, 0, 0);
    run(8, 1, 0, 0);
    run(8, 0, 0, 0);
    st[2] = 4'd7;
    run(9, 0, 1, 0);
    run(2, 0, 0, 0);
    run(8, 0, 1, 0);
    run(12, 0, 0, 0);

    // reject on a zero stat, then accept once it is non-zero
    st[2] = 4'd0;
    run(9, 0, 1, 0);
    run(6, 0, 0, 0);
    st[2] = 4'd3;
    run(9, 0, 1, 0);
    run(15, 0, 0, 0);

    // reset four cycles into cooldown, then quiet
    run(12, 0, 1, 0);
    do_reset();
    run(50, 0, 0, 0);

    // simultaneous select+next, then back+select
    set_stats(5);
    run(9, 1, 1, 0);
    run(15, 0, 0, 0);
    run(9, 0, 1, 1);
    run(15, 0, 0, 0);

    // randomized phase
    for (int b = 0; b < 3; b++) begin
      hold[b] = 0;
      val[b] = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          val[b] = ($urandom_range(0, 9) < 3);
          hold[b] = (b == 2) ? $urandom_range(1, 30) : $urandom_range(1, 12);
          if (b == 2 && val[b]) hold[b] = $urandom_range(1, 8);
        end
        hold[b]--;
      end
      for (int i = 0; i < 6; i++)
        st[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 599) == 0) do_reset();
      else run(1, val[0], val[1], val[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/care_menu.md
# care_menu

Player-side care controller for the pet. Debounces the three front-panel buttons, runs a cursor menu over the six care actions, and issues single-cycle action pulses on the 8-bit action bus consumed by the stat tracker's `inputs` port. It reads the six current stat levels back so that no action is fired against a stat that is already 0. A cooldown enforces a minimum spacing between consecutive actions.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000: consecutive stable cycles before a button level is accepted (10 ms at 27 MHz); minimum 1.
- `COOLDOWN_CYCLES`, default 27_000_000: cycles the block stays busy after a fired action (1 s); minimum 1.
- `clk`  in  1  27 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  raw button, asynchronous, active-high.
- `btn_select`  in  1  raw button, asynchronous, active-high.
- `btn_back`  in  1  raw button, asynchronous, active-high.
- `hunger`, `happiness`, `health`, `hygiene`, `energy`, `social`  in  4 each  current stat levels (menu indices 0..5).
- `action`  out  8  one-hot, single-cycle action pulse. Bit i = menu index i. Bits 7:6 are always 0.
- `cursor`  out  3  current menu index, 0..5.
- `busy`  out  1  high while an action is firing or cooling down.
- `reject`  out  1  single-cycle pulse when a select is refused.

## Operation
- **Button conditioning (per button).**
  - 2-flop synchronizer.
  - Debounce counter. The accepted level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce back clears the counter.
  - Press event: a registered 1-cycle pulse on the 0→1 transition of the accepted level. Release produces no event.
- **Event priority in the same cycle:** back > select > next. Lower-priority events in that cycle are dropped.
- **FSM states:** BROWSE, FIRE, COOLDOWN.
  - **BROWSE**
    - next: cursor = (cursor == 5) ? 0 : cursor + 1.
    - back: cursor = 0.
    - select with stat[cursor] == 0: `reject` = 1 for one cycle; stay in BROWSE.
    - select with stat[cursor] != 0: go to FIRE.
    - The stat is sampled in the cycle of the select event.
  - **FIRE** (exactly 1 cycle): `action[cursor]` = 1, `busy` = 1, then go to COOLDOWN. The cursor is unchanged.
  - **COOLDOWN:** `busy` = 1 for exactly `COOLDOWN_CYCLES` cycles, then return to BROWSE.
    - All press events in this state are discarded, not queued.
    - Debouncers keep running, so a button still held when cooldown ends produces no new event until it is released and pressed again.
- **Counter widths:** debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits; cooldown counter is $clog2(COOLDOWN_CYCLES+1) bits. Neither wraps: each saturates at its terminal count or is cleared.
- **Stat inputs** are treated as synchronous to `clk`. They may change on any cycle; only the select-cycle value matters.

## Timing
- **Reset values** (asserted asynchronously, held while `reset_n` = 0):
  - Outputs: `action` = 0, `cursor` = 0, `busy` = 0, `reject` = 0.
  - Internal: state = BROWSE, accepted levels = 0, all counters = 0.
- **Reset mid-FIRE or mid-COOLDOWN:** all outputs return to reset values immediately. No partial pulse is completed after reset releases.
- **Button held through reset release:** treated as a fresh press. The event fires `DEBOUNCE_CYCLES`+3 cycles after the first rising `clk` edge with `reset_n` = 1.
- **Latency:**
  - A raw 0→1 held stable, first sampled at edge t, produces its press event in the cycle after edge t+`DEBOUNCE_CYCLES`+2.
  - `cursor` update, `reject`, or entry into FIRE (`action` high) is visible one cycle after the event.
- **Busy window:**
  - `busy` rises in the same cycle as the `action` pulse.
  - It stays high for `COOLDOWN_CYCLES`+1 cycles in total.
  - The first cycle with `busy` = 0 is back in BROWSE and accepts events.
- **Pulse rules:** `action` and `reject` are never both high. At most one `action` bit is high in any cycle.

## Test plan
Use `DEBOUNCE_CYCLES` = 4 and `COOLDOWN_CYCLES` = 8 for all scenarios.
- **Debounce / bounce rejection:** `btn_next` toggles every 2 cycles for 20 cycles, then holds high → exactly one cursor increment (0→1), occurring 8 cycles after the final rise. No increment during the bouncing.
- **Wrap and back:** six clean next presses → `cursor` sequence 1, 2, 3, 4, 5, 0. Then next, next, back → 1, 2, 0.
- **Fire and cooldown:** cursor = 2, `health` = 7, select press → `action` = 8'b0000_0100 for exactly 1 cycle. `busy` is high for 9 cycles. A select pressed during cooldown produces no second pulse.
- **Reject:** cursor = 4, `energy` = 0, select → `reject` is high for 1 cycle, `action` stays 0, `busy` stays 0. Then set `energy` = 3 and select → `action` = 8'b0001_0000.
- **Simultaneous events:** `btn_select` and `btn_next` debounced on the same cycle, cursor = 0, `hunger` = 5 → `action` = 8'b0000_0001 and cursor stays 0. Then back + select on the same cycle → cursor = 0, no action.
- **Reset mid-cooldown:** drive `reset_n` = 0 four cycles into cooldown → `busy`, `action`, `reject` and `cursor` all read 0 in the same cycle. After release with no buttons held, no spurious events occur for 50 cycles.
